// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// reg_bank_pkg : shared types and helpers for the reg_bank register file
// Revision     : 1.0
// ============================================================================
package reg_bank_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Byte-lane merge; callers apply it across every lane of a word.
    function automatic logic [7:0] be_merge_byte(
        input logic [7:0] i_old,
        input logic [7:0] i_new,
        input logic       i_be
    );
        return i_be ? i_new : i_old;
    endfunction

    function automatic bit params_ok(input int unsigned i_width, input int unsigned i_depth);
        return (i_width >= 8) && ((i_width % 8) == 0) &&
               (i_depth >= 2) && ((i_depth & (i_depth - 1)) == 0);
    endfunction

endpackage : reg_bank_pkg
`default_nettype wire

// File: rtl/reg_bank_if.sv
`default_nettype none
// ============================================================================
// reg_bank_if : write/read/clear bus between command decoder and reg_bank
// Revision    : 1.0
// ============================================================================
interface reg_bank_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = WIDTH / 8;

    logic             load;
    logic [AW-1:0]    load_addr;
    logic [BW-1:0]    load_be;
    logic [WIDTH-1:0] load_data;
    logic             clear;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_hit;
    logic             busy;
    logic             load_drop;

    modport master (
        output load, load_addr, load_be, load_data, clear, rd_en, rd_addr,
        input  rd_data, rd_valid, rd_hit, busy, load_drop
    );

    modport slave (
        input  load, load_addr, load_be, load_data, clear, rd_en, rd_addr,
        output rd_data, rd_valid, rd_hit, busy, load_drop
    );

endinterface : reg_bank_if
`default_nettype wire

// File: rtl/reg_bank_entry.sv
`default_nettype none
// ============================================================================
// reg_bank_entry : one WIDTH-bit word plus valid flag, byte-enable write,
//                  synchronous zero
// Revision       : 1.0
// ============================================================================
module reg_bank_entry
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               i_we,
    input  wire [WIDTH/8-1:0] i_be,
    input  wire [WIDTH-1:0]   i_data,
    input  wire               i_clr,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [WIDTH-1:0] w_merged;

    for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_byte
        assign w_merged[8*gi +: 8] = be_merge_byte(r_data[8*gi +: 8], i_data[8*gi +: 8], i_be[gi]);
    end

    // Valid is set on any accepted write, even with no byte lanes enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_we) begin
            r_data  <= w_merged;
            r_valid <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule : reg_bank_entry
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
// reg_bank : DEPTH x WIDTH register bank with per-entry valid, byte-enable
//            writes, registered reads with optional bypass, sequenced clear
// Revision : 1.0
// ============================================================================
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1
) (
    input  wire       clk,
    input  wire       rst_n,
    reg_bank_if.slave bus
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);

    if (!params_ok(WIDTH, DEPTH)) begin : g_param_check
        $fatal(1, "reg_bank: WIDTH must be a multiple of 8 and DEPTH a power of two >= 2");
    end

    state_e           r_state;
    state_e           w_state_next;
    logic [AW-1:0]    r_ptr;
    logic             w_sweep;
    logic             w_load_ok;
    logic             w_load_rej;

    logic [WIDTH-1:0] w_ent_data [DEPTH];
    logic [DEPTH-1:0] w_ent_valid;

    logic [WIDTH-1:0] w_rd_old;
    logic             w_rd_old_hit;
    logic [WIDTH-1:0] w_rd_fwd_data;
    logic             w_fwd;
    logic             w_rd_swept;
    logic [WIDTH-1:0] w_rd_next_data;
    logic             w_rd_next_hit;

    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_rd_hit;
    logic             r_load_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.clear)            w_state_next = ST_CLEAR;
            ST_CLEAR: if (r_ptr == c_LAST_IDX)  w_state_next = ST_IDLE;
            default:                            w_state_next = ST_IDLE;
        endcase
    end

    // Clear has priority over a coincident load; any load outside IDLE is rejected.
    always_comb begin
        w_sweep    = (r_state == ST_CLEAR);
        w_load_ok  = bus.load && (r_state == ST_IDLE) && !bus.clear;
        w_load_rej = bus.load && !w_load_ok;
    end

    // Pointer parks at 0 outside a sweep so a new sweep always starts at entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_sweep && (r_ptr != c_LAST_IDX)) begin
            r_ptr <= r_ptr + 1'b1;
        end else begin
            r_ptr <= '0;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        reg_bank_entry #(
            .WIDTH (WIDTH)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_we    (w_load_ok && (bus.load_addr == AW'(gi))),
            .i_be    (bus.load_be),
            .i_data  (bus.load_data),
            .i_clr   (w_sweep && (r_ptr == AW'(gi))),
            .o_data  (w_ent_data[gi]),
            .o_valid (w_ent_valid[gi])
        );
    end

    assign w_rd_old     = w_ent_data[bus.rd_addr];
    assign w_rd_old_hit = w_ent_valid[bus.rd_addr];
    assign w_rd_swept   = w_sweep && (r_ptr == bus.rd_addr);

    for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_fwd_byte
        assign w_rd_fwd_data[8*gi +: 8] =
            be_merge_byte(w_rd_old[8*gi +: 8], bus.load_data[8*gi +: 8], bus.load_be[gi]);
    end

    if (BYPASS != 0) begin : g_bypass
        assign w_fwd = w_load_ok && (bus.load_addr == bus.rd_addr);
    end else begin : g_no_bypass
        assign w_fwd = 1'b0;
    end

    always_comb begin
        w_rd_next_data = w_rd_old;
        w_rd_next_hit  = w_rd_old_hit;
        if (w_rd_swept) begin
            w_rd_next_data = '0;
            w_rd_next_hit  = 1'b0;
        end else if (w_fwd) begin
            w_rd_next_data = w_rd_fwd_data;
            w_rd_next_hit  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_hit    <= 1'b0;
            r_load_drop <= 1'b0;
        end else begin
            r_rd_valid  <= bus.rd_en;
            r_load_drop <= w_load_rej;
            if (bus.rd_en) begin
                r_rd_data <= w_rd_next_data;
                r_rd_hit  <= w_rd_next_hit;
            end
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_hit    = r_rd_hit;
    assign bus.busy      = w_sweep;
    assign bus.load_drop = r_load_drop;

endmodule : reg_bank
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
// tb_reg_bank : self-checking bench for reg_bank (BYPASS=1 and BYPASS=0 side by side)
// Revision    : 1.0
// ============================================================================
module tb_reg_bank;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();
    reg_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();

    reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    typedef struct {
        int          due;
        logic [15:0] d1;
        logic [15:0] d0;
        logic        h1;
        logic        h0;
    } rd_exp_t;

    typedef struct {
        bit          ld;
        int          la;
        logic [1:0]  be;
        logic [15:0] d;
        bit          clr;
        bit          rd;
        int          ra;
        bit          chk;
        logic [15:0] e1;
        logic [15:0] e0;
        logic        h1;
        logic        h0;
    } vec_t;

    rd_exp_t     q[$];
    rd_exp_t     mon_e;
    vec_t        tab[$];
    logic [15:0] m_mem [DEPTH];
    logic [3:0]  m_vld;
    bit          m_busy;
    int          m_ptr;
    bit          exp_busy;
    bit          exp_drop;
    bit          mon_en;
    int          cyc;
    int          busy_cnt;
    int          n_chk;
    int          n_err;

    function automatic logic [15:0] merge16(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        logic [15:0] r;
        for (int i = 0; i < 2; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy1", 32'(bus1.busy), 32'(exp_busy));
            check("busy0", 32'(bus0.busy), 32'(exp_busy));
            check("load_drop1", 32'(bus1.load_drop), 32'(exp_drop));
            check("load_drop0", 32'(bus0.load_drop), 32'(exp_drop));
            if (bus1.busy) busy_cnt++;
            if (q.size() > 0 && q[0].due == cyc) begin
                mon_e = q.pop_front();
                check("rd_valid1", 32'(bus1.rd_valid), 32'd1);
                check("rd_valid0", 32'(bus0.rd_valid), 32'd1);
                check("rd_data1",  32'(bus1.rd_data),  32'(mon_e.d1));
                check("rd_hit1",   32'(bus1.rd_hit),   32'(mon_e.h1));
                check("rd_data0",  32'(bus0.rd_data),  32'(mon_e.d0));
                check("rd_hit0",   32'(bus0.rd_hit),   32'(mon_e.h0));
            end else begin
                check("rd_valid1_idle", 32'(bus1.rd_valid), 32'd0);
                check("rd_valid0_idle", 32'(bus0.rd_valid), 32'd0);
            end
        end
    end

    task automatic set_inputs(input bit ld, input int la, input logic [1:0] be, input logic [15:0] d,
                              input bit clr, input bit rd, input int ra);
        bus1.load = ld;  bus1.load_addr = 2'(la); bus1.load_be = be; bus1.load_data = d;
        bus1.clear = clr; bus1.rd_en = rd; bus1.rd_addr = 2'(ra);
        bus0.load = ld;  bus0.load_addr = 2'(la); bus0.load_be = be; bus0.load_data = d;
        bus0.clear = clr; bus0.rd_en = rd; bus0.rd_addr = 2'(ra);
    endtask

    // One clock of stimulus; predicts read results and updates the reference model.
    task automatic drive(input bit ld, input int la, input logic [1:0] be, input logic [15:0] d,
                         input bit clr, input bit rd, input int ra,
                         input bit use_tab, input logic [15:0] t1, input logic [15:0] t0,
                         input logic th1, input logic th0);
        bit      acc;
        rd_exp_t e;
        set_inputs(ld, la, be, d, clr, rd, ra);
        acc = ld && !m_busy && !clr;
        if (rd) begin
            if (m_busy && m_ptr == ra) begin
                e.d1 = '0; e.d0 = '0; e.h1 = 1'b0; e.h0 = 1'b0;
            end else begin
                e.d0 = m_mem[ra];
                e.h0 = m_vld[ra];
                if (acc && la == ra) begin
                    e.d1 = merge16(m_mem[ra], d, be);
                    e.h1 = 1'b1;
                end else begin
                    e.d1 = e.d0;
                    e.h1 = e.h0;
                end
            end
            if (use_tab) begin
                e.d1 = t1; e.d0 = t0; e.h1 = th1; e.h0 = th0;
            end
            e.due = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            m_mem[la] = merge16(m_mem[la], d, be);
            m_vld[la] = 1'b1;
        end
        if (m_busy) begin
            m_mem[m_ptr] = '0;
            m_vld[m_ptr] = 1'b0;
            if (m_ptr == DEPTH - 1) begin
                m_busy = 1'b0;
                m_ptr  = 0;
            end else begin
                m_ptr++;
            end
        end else if (clr) begin
            m_busy = 1'b1;
            m_ptr  = 0;
        end
        exp_busy = m_busy;
        exp_drop = ld && !acc;
    endtask

    task automatic idle();
        drive(0, 0, 2'b00, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
    endtask

    task automatic ld(input int la, input logic [1:0] be, input logic [15:0] d);
        drive(1, la, be, d, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
    endtask

    task automatic rdx(input int ra, input logic [15:0] ed, input logic eh);
        drive(0, 0, 2'b00, 16'h0, 0, 1, ra, 1, ed, ed, eh, eh);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_vld    = '0;
        m_busy   = 1'b0;
        m_ptr    = 0;
        exp_busy = 1'b0;
        exp_drop = 1'b0;
        q.delete();
    endtask

    task automatic do_reset();
        set_inputs(0, 0, 2'b00, 16'h0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        check("rst_busy1",   32'(bus1.busy),      32'd0);
        check("rst_busy0",   32'(bus0.busy),      32'd0);
        check("rst_valid1",  32'(bus1.rd_valid),  32'd0);
        check("rst_drop1",   32'(bus1.load_drop), 32'd0);
        check("rst_data1",   32'(bus1.rd_data),   32'd0);
        check("rst_hit1",    32'(bus1.rd_hit),    32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; mon_en = 0; busy_cnt = 0;
        model_reset();
        set_inputs(0, 0, 2'b00, 16'h0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1;

        //        ld la be     data     clr rd ra chk e1        e0        h1 h0
        tab.push_back('{0, 0, 2'b00, 16'h0000, 0, 1, 0, 1, 16'h0000, 16'h0000, 0, 0});
        tab.push_back('{0, 0, 2'b00, 16'h0000, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0});
        tab.push_back('{0, 0, 2'b00, 16'h0000, 0, 1, 2, 1, 16'h0000, 16'h0000, 0, 0});
        tab.push_back('{0, 0, 2'b00, 16'h0000, 0, 1, 3, 1, 16'h0000, 16'h0000, 0, 0});
        tab.push_back('{1, 1, 2'b11, 16'h00FE, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0});
        tab.push_back('{1, 1, 2'b10, 16'h0FE6, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0});
        tab.push_back('{0, 0, 2'b00, 16'h0000, 0, 1, 1, 1, 16'h0FFE, 16'h0FFE, 1, 1});
        tab.push_back('{1, 2, 2'b11, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0});
        tab.push_back('{1, 2, 2'b01, 16'hAB55, 0, 1, 2, 1, 16'h1255, 16'h1234, 1, 1});
        tab.push_back('{0, 0, 2'b00, 16'h0000, 0, 1, 2, 1, 16'h1255, 16'h1255, 1, 1});
        tab.push_back('{1, 0, 2'b01, 16'hC377, 0, 1, 0, 1, 16'h0077, 16'h0000, 1, 0});
        tab.push_back('{0, 0, 2'b00, 16'h0000, 0, 1, 0, 1, 16'h0077, 16'h0077, 1, 1});
        tab.push_back('{1, 3, 2'b00, 16'h9999, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0});
        tab.push_back('{0, 0, 2'b00, 16'h0000, 0, 1, 3, 1, 16'h0000, 16'h0000, 1, 1});
        tab.push_back('{0, 0, 2'b00, 16'h0000, 0, 1, 1, 1, 16'h0FFE, 16'h0FFE, 1, 1});
        tab.push_back('{0, 0, 2'b00, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0});

        foreach (tab[i]) begin
            drive(tab[i].ld, tab[i].la, tab[i].be, tab[i].d, tab[i].clr, tab[i].rd, tab[i].ra,
                  tab[i].chk, tab[i].e1, tab[i].e0, tab[i].h1, tab[i].h0);
        end
        check("hold_data1", 32'(bus1.rd_data), 32'h0FFE);
        check("hold_hit1",  32'(bus1.rd_hit),  32'd1);

        // Full bank, clear sweep with a rejected load and reads mid-sweep.
        for (int i = 0; i < DEPTH; i++) ld(i, 2'b11, 16'hFFFF);
        busy_cnt = 0;
        drive(0, 0, 2'b00, 16'h0, 1, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        drive(0, 0, 2'b00, 16'h0, 0, 1, 2, 1, 16'hFFFF, 16'hFFFF, 1, 1);
        drive(1, 0, 2'b11, 16'h5A5A, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0);
        idle();
        idle();
        idle();
        check("sweep_busy_cycles", 32'(busy_cnt), 32'd4);
        for (int i = 0; i < DEPTH; i++) rdx(i, 16'h0000, 1'b0);

        // Load and clear together in IDLE; load on the cycle busy falls is kept.
        busy_cnt = 0;
        drive(1, 3, 2'b11, 16'hBEEF, 1, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        repeat (4) idle();
        ld(2, 2'b11, 16'hC0DE);
        rdx(3, 16'h0000, 1'b0);
        rdx(2, 16'hC0DE, 1'b1);
        check("clr_ld_busy_cycles", 32'(busy_cnt), 32'd4);

        // Reset in the second cycle of a sweep, then a fresh full sweep.
        ld(0, 2'b11, 16'h1111);
        drive(0, 0, 2'b00, 16'h0, 1, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        idle();
        do_reset();
        idle();
        for (int i = 0; i < DEPTH; i++) rdx(i, 16'h0000, 1'b0);
        ld(1, 2'b11, 16'h2222);
        busy_cnt = 0;
        drive(0, 0, 2'b00, 16'h0, 1, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        repeat (5) idle();
        check("post_rst_busy_cycles", 32'(busy_cnt), 32'd4);
        rdx(1, 16'h0000, 1'b0);
        idle();
        idle();
        check("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_reg_bank
`default_nettype wire

// File: doc/reg_bank.md
# reg_bank

Parametrised successor to the single 16-bit load register. It holds DEPTH entries of WIDTH bits, each with its own valid flag. Writes support byte enables, reads are registered, and a sequenced clear sweeps the bank. It sits between the command decoder and the DDR3 sequencer, where it holds mode/timing words that were previously kept in discrete A/B registers.

## Interface
Parameters:
- WIDTH, 16: entry width in bits; multiple of 8, minimum 8.
- DEPTH, 4: number of entries; power of two, minimum 2.
- BYPASS, 1: 1 = same-cycle write data forwarded to a read of the same address; 0 = read returns pre-write contents.
- Derived: AW = $clog2(DEPTH), BW = WIDTH/8.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  write strobe.
- load_addr  in  AW  write entry index.
- load_be  in  BW  byte enables; bit i covers data[8i+7:8i].
- load_data  in  WIDTH  write data.
- clear  in  1  single-cycle request to start a bank clear.
- rd_en  in  1  read strobe.
- rd_addr  in  AW  read entry index.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse, asserted the cycle after an accepted rd_en.
- rd_hit  out  1  valid flag of the entry read; qualified by rd_valid.
- busy  out  1  high while a clear sweep is in progress.
- load_drop  out  1  one-cycle pulse; a load was rejected.

## Operation
- Reset (async assert): all entries, all valid flags, rd_data, rd_valid, rd_hit, busy and load_drop go to 0; FSM goes to IDLE; sweep pointer goes to 0.
- FSM states are IDLE and CLEAR.
- IDLE + clear: go to CLEAR, pointer = 0, busy = 1 from the next cycle.
- CLEAR: each cycle zeroes entry[pointer] and its valid flag, then pointer increments. After clearing entry DEPTH-1, return to IDLE; busy drops the same edge.
- clear is ignored while in CLEAR.
- Accepted load (IDLE, no clear): entry[load_addr] bytes with load_be=1 take load_data; other bytes are unchanged. Valid is set even when load_be is all-zero.
- Rejected load: load during CLEAR, or load and clear together in IDLE (clear wins). The entry is unchanged and load_drop pulses the following cycle.
- Reads are always accepted, including during CLEAR.
  - A read during CLEAR returns the current entry contents: zero if the entry has already been swept.
  - A read of the entry being swept in that same cycle returns 0 with rd_hit 0.
- Read/write same address, same cycle:
  - BYPASS=1: rd_data is the byte-merged new value; rd_hit = 1.
  - BYPASS=0: rd_data is the old value; rd_hit is the old flag.
- rd_data and rd_hit hold their last values while rd_en is low.

## Timing
- Write latency: visible to a read issued on the next cycle (or on the same cycle with BYPASS=1).
- Read latency: 1 cycle, rd_en at edge N gives rd_data/rd_valid after edge N+1.
- Clear duration: busy is high for exactly DEPTH cycles. A load accepted in the cycle busy falls is written normally.
- Reset mid-sweep aborts the sweep; every entry is zero after reset regardless.
- Index wrap is impossible by construction (AW bits, DEPTH power of two). The sweep pointer must not advance past DEPTH-1.

## Structure
- Package reg_bank_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CLEAR);
  - a function computing the byte-enable merge (old, new, be);
  - a width check (WIDTH % 8 == 0, DEPTH power of two) elaborated as a fatal assertion.
- Sub-module reg_bank_entry: one WIDTH register plus valid flag, with byte-enable write and synchronous zero. It is instantiated DEPTH times in a generate loop.
- The top level holds the FSM, sweep pointer, read mux/bypass and output registers.

## Test plan
All scenarios use WIDTH=16, DEPTH=4.
- Reset, then read entries 0..3: rd_data=16'h0000, rd_hit=0, busy=0, one rd_valid pulse per read, each one cycle after its rd_en.
- Load addr 1, be=2'b11, data 16'h00FE; next cycle load addr 1, be=2'b10, data 16'h0FE6; read addr 1 gives 16'h0FFE, rd_hit=1.
- BYPASS=1: entry 2 = 16'h1234; same-cycle load addr 2, be=2'b01, data 16'hAB55 with read addr 2 gives 16'h1255. Rerun with BYPASS=0: gives 16'h1234.
- Fill all entries with 16'hFFFF, pulse clear:
  - busy is high for 4 cycles;
  - a load issued in cycle 2 of the sweep produces one load_drop pulse and is not stored;
  - afterwards all reads give 0, rd_hit=0.
- Simultaneous load (addr 3, 16'hBEEF) and clear in IDLE: load_drop pulses, entry 3 reads 0 after the sweep.
- Assert rst_n low mid-sweep (cycle 2), release: busy=0, FSM in IDLE, all entries 0; a new clear runs a full 4-cycle sweep.
